// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
package i2c_cfg_pkg;

   // Sequencer states
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_POWERUP,
      ST_LOAD,
      ST_START,
      ST_WAIT,
      ST_DELAY,
      ST_GAP,
      ST_NEXT,
      ST_DONE,
      ST_ERROR
   } seq_state_e;

   // Address value that turns a table entry into a timed delay of data*DELAY_UNIT cycles
   localparam logic [7:0] DELAY_MARKER = 8'hFF;

   // One table entry: {addr[15:8], data[7:0]}
   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } cfg_entry_t;

   // Index width for a table of n entries, never below 1 bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2c_config_rom.sv
// Per-device configuration table: index -> {addr, data}. Indices at or
// beyond NUM_REGS read as 16'h0000.
module i2c_config_rom
   import i2c_cfg_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = 4
) (
   input  logic [IDX_W-1:0] idx_i,
   output cfg_entry_t       entry_o
);

   logic [31:0] idx_ext;

   // Combinational table lookup; edit the case items for the target device
   always_comb begin
      idx_ext = 32'(idx_i);
      entry_o = '0;
      if (idx_ext < 32'(NUM_REGS)) begin
         case (idx_ext)
            32'd0:   entry_o = '{addr: 8'h12, data: 8'h80};   // soft reset
            32'd1:   entry_o = '{addr: 8'h3A, data: 8'h04};   // output format
            32'd2:   entry_o = '{addr: 8'h40, data: 8'hD0};   // clock control
            32'd3:   entry_o = '{addr: DELAY_MARKER, data: 8'h03}; // settle: 3 delay units
            32'd4:   entry_o = '{addr: 8'h6B, data: 8'h01};   // enable streaming
            default: entry_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the configuration table, handing each (addr, data) pair to the
// I2C frame stage and pacing frames on its complete flag. Delay entries
// stall the walk for data*DELAY_UNIT cycles instead of issuing a frame.
module i2c_config_sequencer
   import i2c_cfg_pkg::*;
#(
   parameter int NUM_REGS       = 16,
   parameter int AUTO_START     = 1,
   parameter int POWERUP_CYCLES = 1000,
   parameter int GAP_CYCLES     = 8,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int DELAY_UNIT     = 1000,
   localparam int IDX_W         = idx_width(NUM_REGS)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_go,
   input  logic             i_complete,
   output logic [7:0]       o_register_addr,
   output logic [7:0]       o_data,
   output logic             o_start,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error,
   output logic [IDX_W-1:0] o_index
);

   // Terminal counts; each phase counter runs 0..LAST inclusive
   localparam int          GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
   localparam logic [31:0] GAP_LAST = 32'(GAP_EFF - 1);
   localparam logic [31:0] PWR_LAST = 32'((POWERUP_CYCLES > 0) ? POWERUP_CYCLES - 1 : 0);
   localparam logic [31:0] TMO_LAST = 32'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   seq_state_e       state_q;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      cnt_q;
   logic [7:0]       addr_q;
   logic [7:0]       data_q;
   logic             start_q;
   logic             busy_q;
   logic             done_q;
   logic             error_q;
   logic             cplt_q;

   cfg_entry_t       rom_entry;
   logic             cplt_rise;
   logic [31:0]      delay_len;
   logic             delay_last;

   i2c_config_rom #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_rom (
      .idx_i   (idx_q),
      .entry_o (rom_entry)
   );

   // Only a fresh rising edge of complete ends a frame; a level held over
   // from the previous frame must not advance the walk.
   // Delay length is data*DELAY_UNIT; zero length still spends one cycle.
   always_comb begin
      cplt_rise  = i_complete & ~cplt_q;
      delay_len  = 32'(data_q) * 32'(DELAY_UNIT);
      delay_last = (delay_len == 32'd0) || (cnt_q == delay_len - 32'd1);
   end

   // Sequencer FSM with registered outputs; reset aborts any frame at once
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         cplt_q  <= 1'b0;
      end else begin
         cplt_q <= i_complete;
         case (state_q)
            // Auto-start fires once after reset; otherwise wait for go
            ST_IDLE: begin
               if ((AUTO_START != 0) || i_go) begin
                  state_q <= ST_POWERUP;
                  idx_q   <= '0;
                  cnt_q   <= '0;
                  error_q <= 1'b0;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end

            ST_POWERUP: begin
               if ((POWERUP_CYCLES == 0) || (cnt_q == PWR_LAST)) begin
                  state_q <= ST_LOAD;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end

            // Latch the entry; addr/data stay put until the next LOAD
            ST_LOAD: begin
               addr_q <= rom_entry.addr;
               data_q <= rom_entry.data;
               cnt_q  <= '0;
               if (rom_entry.addr == DELAY_MARKER) state_q <= ST_DELAY;
               else                                state_q <= ST_START;
            end

            ST_START: begin
               start_q <= 1'b1;
               cnt_q   <= '0;
               state_q <= ST_WAIT;
            end

            // Frame in flight: finish on complete edge or give up on timeout
            ST_WAIT: begin
               if (cplt_rise) begin
                  start_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= ST_GAP;
               end else if (cnt_q == TMO_LAST) begin
                  start_q <= 1'b0;
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_ERROR;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end

            ST_DELAY: begin
               if (delay_last) begin
                  cnt_q   <= '0;
                  state_q <= ST_NEXT;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end

            // Keep start low long enough for the frame stage to see a new edge
            ST_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q   <= '0;
                  state_q <= ST_NEXT;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end

            ST_NEXT: begin
               if (idx_q == LAST_IDX) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
               end else begin
                  idx_q   <= idx_q + 1'b1;
                  state_q <= ST_LOAD;
               end
            end

            // Terminal states hold everything until an explicit go
            ST_DONE, ST_ERROR: begin
               if (i_go) begin
                  state_q <= ST_POWERUP;
                  idx_q   <= '0;
                  cnt_q   <= '0;
                  error_q <= 1'b0;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end

            default: begin
               start_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_register_addr = addr_q;
   assign o_data          = data_q;
   assign o_start         = start_q;
   assign o_busy          = busy_q;
   assign o_done          = done_q;
   assign o_error         = error_q;
   assign o_index         = idx_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Scoreboard bench: the stimulus pushes expected frames, a monitor pops and
// checks them on every o_start rise, a responder plays the frame stage.
module tb_i2c_config_sequencer;

   localparam int M_NORMAL = 0;
   localparam int M_HOLD   = 1;
   localparam int M_NEVER  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n  = 1'b0;
   logic go_a   = 1'b0;
   logic cplt_a = 1'b0;
   logic go_b   = 1'b0;
   logic cplt_b = 1'b0;

   logic [7:0] addr_a, data_a, addr_b, data_b;
   logic       start_a, busy_a, done_a, err_a;
   logic       start_b, busy_b, done_b, err_b;
   logic [2:0] idx_a, idx_b;

   i2c_config_sequencer #(
      .NUM_REGS(5), .AUTO_START(1), .POWERUP_CYCLES(10),
      .GAP_CYCLES(4), .TIMEOUT_CYCLES(50), .DELAY_UNIT(5)
   ) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_go(go_a), .i_complete(cplt_a),
      .o_register_addr(addr_a), .o_data(data_a), .o_start(start_a),
      .o_busy(busy_a), .o_done(done_a), .o_error(err_a), .o_index(idx_a)
   );

   i2c_config_sequencer #(
      .NUM_REGS(5), .AUTO_START(0), .POWERUP_CYCLES(10),
      .GAP_CYCLES(4), .TIMEOUT_CYCLES(50), .DELAY_UNIT(5)
   ) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_go(go_b), .i_complete(cplt_b),
      .o_register_addr(addr_b), .o_data(data_b), .o_start(start_b),
      .o_busy(busy_b), .o_done(done_b), .o_error(err_b), .o_index(idx_b)
   );

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      int         gap;   // expected o_start low cycles before this frame; 0 = unchecked
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   mode = M_NORMAL;
   int   gen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Hand-derived frame list for ROM {12/80, 3A/04, 40/D0, FF/03, 6B/01}:
   // normal gap = GAP 4 + NEXT + LOAD + START = 7;
   // across the delay entry = 4 + NEXT + LOAD + DELAY 15 + NEXT + LOAD + START = 24.
   task automatic push_frames(input int n);
      exp_t tbl [4];
      tbl[0] = '{8'h12, 8'h80, 0};
      tbl[1] = '{8'h3A, 8'h04, 7};
      tbl[2] = '{8'h40, 8'hD0, 7};
      tbl[3] = '{8'h6B, 8'h01, 24};
      for (int i = 0; i < n; i++) sb_q.push_back(tbl[i]);
   endtask

   task automatic pulse_go();
      go_a = 1'b1;
      @(negedge clk);
      go_a = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int t = 0;
      while (!done_a && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_done"}, 32'(done_a), 32'd1);
      chk({nm, "_busy"}, 32'(busy_a), 32'd0);
      chk({nm, "_index"}, 32'(idx_a), 32'd4);
      chk({nm, "_error"}, 32'(err_a), 32'd0);
      chk({nm, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
   endtask

   // Monitor: frame contents, inter-frame gap, delay span with start held low
   initial begin
      bit   prev = 1'b0;
      int   last_fall = 0;
      int   ff_cnt = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev   = 1'b0;
            ff_cnt = 0;
         end else begin
            if (start_a && !prev) begin
               if (sb_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL frame_unexpected: got addr %0h data %0h expected no frame", addr_a, data_a);
               end else begin
                  e = sb_q.pop_front();
                  chk("frame_addr", 32'(addr_a), 32'(e.addr));
                  chk("frame_data", 32'(data_a), 32'(e.data));
                  chk("frame_busy", 32'(busy_a), 32'd1);
                  if (e.gap > 0) chk("frame_gap", 32'(cyc - last_fall), 32'(e.gap));
               end
            end
            if (!start_a && prev) last_fall = cyc;
            if (addr_a == 8'hFF) begin
               ff_cnt++;
               chk("delay_no_start", 32'(start_a), 32'd0);
            end else if (ff_cnt > 0) begin
               // 15 DELAY cycles + NEXT + LOAD of the following entry
               chk("delay_span", 32'(ff_cnt), 32'd17);
               ff_cnt = 0;
            end
            prev = start_a;
         end
      end
   end

   // Frame-stage model: complete pulse 20 cycles after each o_start rise
   initial begin
      bit rp = 1'b0;
      int g;
      forever begin
         @(negedge clk);
         if (rst_n && start_a && !rp) begin
            g = gen;
            if (mode == M_HOLD) begin
               repeat (30) @(negedge clk);
               chk("hold_no_advance", 32'(start_a), 32'd1);
               cplt_a = 1'b0;
               repeat (2) @(negedge clk);
               cplt_a = 1'b1;
               @(negedge clk);
               chk("hold_edge_fall", 32'(start_a), 32'd0);
               cplt_a = 1'b0;
               mode = M_NORMAL;
            end else if (mode == M_NORMAL) begin
               repeat (20) @(negedge clk);
               if (g == gen && rst_n) begin
                  cplt_a = 1'b1;
                  @(negedge clk);
                  chk("cplt_to_fall", 32'(start_a), 32'd0);
                  cplt_a = 1'b0;
               end
            end
         end
         rp = start_a;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      int t;
      int nb;

      repeat (3) @(negedge clk);
      chk("rst_a_outs", 32'({addr_a, data_a, start_a, busy_a, done_a, err_a, idx_a}), 32'd0);
      chk("rst_b_outs", 32'({addr_b, data_b, start_b, busy_b, done_b, err_b, idx_b}), 32'd0);

      // Auto-start run: IDLE 1 + POWERUP 10 + LOAD + START -> start after 13 edges
      mode = M_NORMAL;
      push_frames(4);
      rst_n = 1'b1;
      t = 0;
      while (!start_a && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("startup_latency", 32'(t), 32'd13);
      wait_done("run1");

      // Leftover high complete must not finish the first frame
      cplt_a = 1'b1;
      mode = M_HOLD;
      push_frames(4);
      pulse_go();
      wait_done("hold");

      // Timeout: no complete ever arrives
      mode = M_NEVER;
      push_frames(1);
      pulse_go();
      t = 0;
      while (!start_a && t < 100) begin
         @(negedge clk);
         t++;
      end
      t = 0;
      while (!err_a && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("timeout_cycles", 32'(t), 32'd50);
      chk("timeout_start", 32'(start_a), 32'd0);
      chk("timeout_busy", 32'(busy_a), 32'd0);
      chk("timeout_done", 32'(done_a), 32'd0);
      chk("timeout_index", 32'(idx_a), 32'd0);
      repeat (5) @(negedge clk);
      chk("error_sticky", 32'(err_a), 32'd1);

      // Recovery via go
      mode = M_NORMAL;
      push_frames(4);
      pulse_go();
      chk("recover_error", 32'(err_a), 32'd0);
      chk("recover_index", 32'(idx_a), 32'd0);
      chk("recover_busy", 32'(busy_a), 32'd1);
      wait_done("recover");

      // Async reset while waiting on entry 1
      push_frames(2);
      pulse_go();
      t = 0;
      while (!(idx_a == 3'd1 && start_a) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("reach_entry1", 32'(start_a), 32'd1);
      repeat (10) @(negedge clk);
      #2;
      rst_n = 1'b0;
      gen++;
      #1;
      chk("async_reset_outs", 32'({addr_a, data_a, start_a, busy_a, done_a, err_a, idx_a}), 32'd0);
      sb_q.delete();
      repeat (3) @(negedge clk);
      push_frames(4);
      rst_n = 1'b1;
      wait_done("post_reset");

      // Manual-start instance: idle without go, POWERUP right after go
      nb = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy_b) nb++;
      end
      chk("b_idle_busy_cycles", 32'(nb), 32'd0);
      chk("b_idle_done", 32'(done_b), 32'd0);
      go_b = 1'b1;
      @(negedge clk);
      go_b = 1'b0;
      chk("b_go_busy", 32'(busy_b), 32'd1);
      chk("b_go_index", 32'(idx_b), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
